i2c_target: RTL

// - I2C target (slave) responder, standard mode, 7-bit addressing, no clock stretching.
// - Pairs with the team's I2C master on the same open-drain bus.
// - Emulates a small register-mapped device for loopback and bring-up:
//   - first written byte = register pointer;
//   - further writes/reads auto-increment the pointer.
// - Storage is external: written bytes are emitted on a strobe port; read data comes from rd_data.

---
 rtl/i2c_target_if.sv | 28 ++
 rtl/i2c_target.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_if.sv
// Register-side port bundle of the I2C target: write strobe, read pointer/data, status.
// Handshake: wr_valid is a one-cycle strobe with no ready; the storage side must
// accept wr_addr/wr_data on every cycle where wr_valid=1. rd_data must reflect
// the byte at rd_addr combinationally (or within HOLD_CYCLES of an rd_addr change).
`timescale 1ns/1ps
interface i2c_target_if #(
  parameter int NUM_REGS = 4
);
  localparam int PW = $clog2(NUM_REGS);

  logic          wr_valid;
  logic [PW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [PW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          busy;
  logic [3:0]    dbg_state;

  modport slave (
    output wr_valid, wr_addr, wr_data, rd_addr, busy, dbg_state,
    input  rd_data
  );

  modport master (
    input  wr_valid, wr_addr, wr_data, rd_addr, busy, dbg_state,
    output rd_data
  );
endinterface

// File: rtl/i2c_target.sv
// I2C target emulating a small register-mapped device (7-bit address, no stretching).
// First written byte sets the register pointer; later writes/reads auto-increment it.
// Optional glitch filter on SCL/SDA: define I2C_TARGET_GLITCH_FILTER_EN.
`timescale 1ns/1ps
module i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h42,
  parameter int NUM_REGS = 4,
  parameter int HOLD_CYCLES = 75
`ifdef I2C_TARGET_GLITCH_FILTER_EN
  ,
  parameter int FILTER_CYCLES = 8
`endif
) (
  input  logic clk,
  input  logic reset,
  inout  wire  scl_pin,
  inout  wire  sda_pin,
  i2c_target_if.slave rif
);
  localparam int PW = $clog2(NUM_REGS);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, WR_DATA, WR_ACK, RD_DATA, RD_ACK_CHK, IGNORE
  } state_t;

  state_t        state, state_d;
  logic [1:0]    scl_sync, sda_sync;
  logic          scl_f, sda_f, scl_q, sda_q;
  logic [2:0]    bit_cnt, cnt_d;
  logic [6:0]    shift, shift_d;
  logic [PW-1:0] ptr, ptr_d;
  logic          rw, rw_d, busy, busy_d;
  logic          wr_valid_d;
  logic [PW-1:0] wr_addr_d;
  logic [7:0]    wr_data_d;
  logic          sda_low, pend_low, sched, sched_low, rel_now;
  logic [HW-1:0] hold_cnt;
  logic          scl_rise, scl_fall, start_c, stop_c;
  logic [7:0]    byte_in;

  // Open-drain: only ever pull low or float; the async reset clears sda_low at once.
  assign sda_pin = sda_low ? 1'b0 : 1'bz;

  // Two-flop synchronizers; idle bus level is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_pin};
      sda_sync <= {sda_sync[0], sda_pin};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_CYCLES + 1);
  logic [FW-1:0] scl_fc, sda_fc;

  // Filtered lines follow the synchronized lines only after FILTER_CYCLES steady cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_f  <= 1'b1;
      sda_f  <= 1'b1;
      scl_fc <= '0;
      sda_fc <= '0;
    end else begin
      if (scl_sync[1] == scl_f) scl_fc <= '0;
      else if (scl_fc == FW'(FILTER_CYCLES - 1)) begin
        scl_f  <= scl_sync[1];
        scl_fc <= '0;
      end else scl_fc <= scl_fc + FW'(1);
      if (sda_sync[1] == sda_f) sda_fc <= '0;
      else if (sda_fc == FW'(FILTER_CYCLES - 1)) begin
        sda_f  <= sda_sync[1];
        sda_fc <= '0;
      end else sda_fc <= sda_fc + FW'(1);
    end
  end
`else
  assign scl_f = scl_sync[1];
  assign sda_f = sda_sync[1];
`endif

  assign scl_rise = scl_f & ~scl_q;
  assign scl_fall = ~scl_f & scl_q;
  assign start_c  = scl_f & scl_q & sda_q & ~sda_f;
  assign stop_c   = scl_f & scl_q & ~sda_q & sda_f;
  assign byte_in  = {shift, sda_f};

  // State, datapath and SDA hold timer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      scl_q        <= 1'b1;
      sda_q        <= 1'b1;
      bit_cnt      <= '0;
      shift        <= '0;
      ptr          <= '0;
      rw           <= 1'b0;
      busy         <= 1'b0;
      rif.wr_valid <= 1'b0;
      rif.wr_addr  <= '0;
      rif.wr_data  <= '0;
      sda_low      <= 1'b0;
      pend_low     <= 1'b0;
      hold_cnt     <= '0;
    end else begin
      state        <= state_d;
      scl_q        <= scl_f;
      sda_q        <= sda_f;
      bit_cnt      <= cnt_d;
      shift        <= shift_d;
      ptr          <= ptr_d;
      rw           <= rw_d;
      busy         <= busy_d;
      rif.wr_valid <= wr_valid_d;
      rif.wr_addr  <= wr_addr_d;
      rif.wr_data  <= wr_data_d;
      if (rel_now) sda_low <= 1'b0;
      if (sched) begin
        hold_cnt <= HW'(HOLD_CYCLES);
        pend_low <= sched_low;
      end else if (rel_now || scl_rise) begin
        hold_cnt <= '0;
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HW'(1);
        if (hold_cnt == HW'(1)) sda_low <= pend_low;
      end
    end
  end

  // Next-state and datapath decisions; START/STOP take priority over bit events.
  always_comb begin
    state_d    = state;
    cnt_d      = bit_cnt;
    shift_d    = shift;
    ptr_d      = ptr;
    rw_d       = rw;
    busy_d     = busy;
    wr_valid_d = 1'b0;
    wr_addr_d  = rif.wr_addr;
    wr_data_d  = rif.wr_data;
    sched      = 1'b0;
    sched_low  = 1'b0;
    rel_now    = 1'b0;
    if (start_c) begin
      state_d = ADDR;
      cnt_d   = '0;
      rel_now = 1'b1;
    end else if (stop_c) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      rel_now = 1'b1;
    end else begin
      case (state)
        ADDR, PTR, WR_DATA: begin
          if (scl_rise) begin
            shift_d = byte_in[6:0];
            cnt_d   = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              cnt_d = '0;
              if (state == ADDR) begin
                if (byte_in[7:1] == TARGET_ADDR) begin
                  state_d = ADDR_ACK;
                  busy_d  = 1'b1;
                  rw_d    = byte_in[0];
                end else begin
                  state_d = IGNORE;
                  busy_d  = 1'b0;
                end
              end else if (state == PTR) begin
                ptr_d   = byte_in[PW-1:0];
                state_d = WR_ACK;
              end else begin
                wr_valid_d = 1'b1;
                wr_addr_d  = ptr;
                wr_data_d  = byte_in;
                ptr_d      = ptr + PW'(1);
                state_d    = WR_ACK;
              end
            end
          end
        end
        ADDR_ACK, WR_ACK: begin
          // bit_cnt 0: ACK not yet clocked; 1: 9th rise seen, release on the next fall.
          if (scl_fall && bit_cnt == 3'd0) begin
            sched     = 1'b1;
            sched_low = 1'b1;
          end else if (scl_rise) begin
            cnt_d = 3'd1;
          end else if (scl_fall) begin
            rel_now = 1'b1;
            cnt_d   = '0;
            if (state == ADDR_ACK && rw) begin
              state_d   = RD_DATA;
              shift_d   = rif.rd_data[6:0];
              sched     = 1'b1;
              sched_low = ~rif.rd_data[7];
            end else if (state == ADDR_ACK) begin
              state_d = PTR;
            end else begin
              state_d = WR_DATA;
            end
          end
        end
        RD_DATA: begin
          if (scl_rise) begin
            if (bit_cnt == 3'd7) begin
              state_d = RD_ACK_CHK;
              cnt_d   = '0;
            end else cnt_d = bit_cnt + 3'd1;
          end else if (scl_fall && bit_cnt != 3'd0) begin
            shift_d   = {shift[5:0], 1'b0};
            sched     = 1'b1;
            sched_low = ~shift[6];
          end
        end
        RD_ACK_CHK: begin
          if (scl_fall && bit_cnt == 3'd0) begin
            sched     = 1'b1;
            sched_low = 1'b0;
          end else if (scl_rise) begin
            if (!sda_f) begin
              ptr_d = ptr + PW'(1);
              cnt_d = 3'd1;
            end else state_d = IGNORE;
          end else if (scl_fall) begin
            state_d   = RD_DATA;
            cnt_d     = '0;
            shift_d   = rif.rd_data[6:0];
            sched     = 1'b1;
            sched_low = ~rif.rd_data[7];
          end
        end
        default: ;
      endcase
    end
  end

  assign rif.rd_addr   = ptr;
  assign rif.busy      = busy;
  assign rif.dbg_state = state;
endmodule
